// File: rtl/pd_pwr_sequencer.sv
// Power-domain sequencer: walks clock-gate, isolation, retention, reset and
// power-switch controls through an ordered off/on sequence with per-step dwell.
module pd_pwr_sequencer #(
  parameter int DLY_W  = 4,
  parameter int TO_CYC = 64
) (
  input  logic             i_aon_clk,
  input  logic             i_soc_pwr_on_rst,
  input  logic             i_sleep_req,
  input  logic             i_pg_en,
  input  logic             i_ret_en,
  input  logic [DLY_W-1:0] i_pwr_off_dly,
  input  logic [DLY_W-1:0] i_pwr_on_dly,
  input  logic             i_pwr_on_ack,
  input  logic             i_err_clr,
  output logic             o_clk_en,
  output logic             o_iso,
  output logic             o_ret,
  output logic             o_rstn,
  output logic             o_pwr_on_req,
  output logic             o_sleep_ack,
  output logic             o_busy,
  output logic             o_err,
  output logic [3:0]       o_state
);

  localparam int TO_W = $clog2(TO_CYC + 1);

  typedef enum logic [3:0] {
    ST_ON       = 4'd0,
    ST_OFF_CLK  = 4'd1,
    ST_OFF_ISO  = 4'd2,
    ST_OFF_RET  = 4'd3,
    ST_OFF_RST  = 4'd4,
    ST_WAIT_OFF = 4'd5,
    ST_OFF      = 4'd6,
    ST_WAIT_ON  = 4'd7,
    ST_ON_RST   = 4'd8,
    ST_ON_RET   = 4'd9,
    ST_ON_ISO   = 4'd10
  } state_t;

  state_t           state;
  logic             clk_en;
  logic             iso;
  logic             ret;
  logic             rstn;
  logic             pwr_on_req;
  logic             sleep_ack;
  logic             busy;
  logic             err;
  logic             pg_l;
  logic             ret_l;
  logic [DLY_W-1:0] dly_l;
  logic [DLY_W-1:0] dly_cnt;
  logic [TO_W-1:0]  to_cnt;

  logic             step_done;
  logic             waiting;
  logic             err_set;

  // A zero delay still dwells for one cycle.
  function automatic logic [DLY_W-1:0] dwell(input logic [DLY_W-1:0] d);
    return (d == '0) ? DLY_W'(1) : d;
  endfunction

  assign step_done = (dly_cnt <= DLY_W'(1));
  assign waiting   = ((state == ST_WAIT_ON) && !i_pwr_on_ack) ||
                     ((state == ST_WAIT_OFF) && i_pwr_on_ack);
  assign err_set   = waiting && (to_cnt == TO_W'(TO_CYC - 1));

  // Sequencer state, domain controls, dwell/timeout counters and error flag.
  always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
    if (i_soc_pwr_on_rst) begin
      state      <= ST_ON;
      clk_en     <= 1'b1;
      iso        <= 1'b0;
      ret        <= 1'b0;
      rstn       <= 1'b1;
      pwr_on_req <= 1'b1;
      sleep_ack  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      pg_l       <= 1'b0;
      ret_l      <= 1'b0;
      dly_l      <= '0;
      dly_cnt    <= '0;
      to_cnt     <= '0;
    end else begin
      if (err_set) begin
        err <= 1'b1;
      end else if (i_err_clr) begin
        err <= 1'b0;
      end

      if (waiting && (to_cnt != TO_W'(TO_CYC))) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      case (state)
        ST_ON: begin
          if (i_sleep_req) begin
            pg_l    <= i_pg_en;
            ret_l   <= i_ret_en;
            dly_l   <= dwell(i_pwr_off_dly);
            dly_cnt <= dwell(i_pwr_off_dly);
            clk_en  <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_OFF_CLK;
          end
        end
        ST_OFF_CLK: begin
          if (!step_done) begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end else if (pg_l) begin
            iso     <= 1'b1;
            dly_cnt <= dly_l;
            state   <= ST_OFF_ISO;
          end else begin
            busy      <= 1'b0;
            sleep_ack <= 1'b1;
            state     <= ST_OFF;
          end
        end
        ST_OFF_ISO: begin
          if (!step_done) begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end else if (ret_l) begin
            ret     <= 1'b1;
            dly_cnt <= dly_l;
            state   <= ST_OFF_RET;
          end else begin
            rstn    <= 1'b0;
            dly_cnt <= dly_l;
            state   <= ST_OFF_RST;
          end
        end
        ST_OFF_RET: begin
          if (!step_done) begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end else begin
            rstn    <= 1'b0;
            dly_cnt <= dly_l;
            state   <= ST_OFF_RST;
          end
        end
        ST_OFF_RST: begin
          if (!step_done) begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end else begin
            pwr_on_req <= 1'b0;
            to_cnt     <= '0;
            state      <= ST_WAIT_OFF;
          end
        end
        ST_WAIT_OFF: begin
          if (!i_pwr_on_ack) begin
            busy      <= 1'b0;
            sleep_ack <= 1'b1;
            state     <= ST_OFF;
          end
        end
        ST_OFF: begin
          if (!i_sleep_req) begin
            pg_l      <= i_pg_en;
            ret_l     <= i_ret_en;
            dly_l     <= dwell(i_pwr_on_dly);
            sleep_ack <= 1'b0;
            if (i_pg_en) begin
              pwr_on_req <= 1'b1;
              to_cnt     <= '0;
              busy       <= 1'b1;
              state      <= ST_WAIT_ON;
            end else begin
              clk_en <= 1'b1;
              state  <= ST_ON;
            end
          end
        end
        ST_WAIT_ON: begin
          if (i_pwr_on_ack) begin
            rstn    <= 1'b1;
            dly_cnt <= dly_l;
            state   <= ST_ON_RST;
          end
        end
        ST_ON_RST: begin
          if (!step_done) begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end else if (ret_l) begin
            ret     <= 1'b0;
            dly_cnt <= dly_l;
            state   <= ST_ON_RET;
          end else begin
            iso     <= 1'b0;
            dly_cnt <= dly_l;
            state   <= ST_ON_ISO;
          end
        end
        ST_ON_RET: begin
          if (!step_done) begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end else begin
            iso     <= 1'b0;
            dly_cnt <= dly_l;
            state   <= ST_ON_ISO;
          end
        end
        ST_ON_ISO: begin
          if (!step_done) begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end else begin
            clk_en <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_ON;
          end
        end
        default: begin
          busy      <= 1'b0;
          sleep_ack <= 1'b0;
          state     <= ST_ON;
        end
      endcase
    end
  end

  assign o_clk_en     = clk_en;
  assign o_iso        = iso;
  assign o_ret        = ret;
  assign o_rstn       = rstn;
  assign o_pwr_on_req = pwr_on_req;
  assign o_sleep_ack  = sleep_ack;
  assign o_busy       = busy;
  assign o_err        = err;
  assign o_state      = state;

endmodule

// File: tb/tb_pd_pwr_sequencer.sv
// Directed bench for pd_pwr_sequencer: a per-cycle vector table plus
// hand-written multi-cycle sequences for full gating, timeout and reset.
module tb_pd_pwr_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sleep = 1'b0;
  logic       pg = 1'b0;
  logic       ret_en = 1'b0;
  logic [3:0] off_dly = 4'd0;
  logic [3:0] on_dly = 4'd0;
  logic       ack = 1'b1;
  logic       clr = 1'b0;

  logic       o_clk_en, o_iso, o_ret, o_rstn, o_pwr_on_req;
  logic       o_sleep_ack, o_busy, o_err;
  logic [3:0] o_state;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;
  logic ret_seen = 1'b0;

  // outs = {clk_en, iso, ret, rstn, pwr_on_req, sleep_ack, busy}
  localparam logic [6:0] RST_OUTS = 7'b1001100;

  pd_pwr_sequencer #(.DLY_W(4), .TO_CYC(64)) dut (
    .i_aon_clk(clk), .i_soc_pwr_on_rst(rst), .i_sleep_req(sleep),
    .i_pg_en(pg), .i_ret_en(ret_en), .i_pwr_off_dly(off_dly),
    .i_pwr_on_dly(on_dly), .i_pwr_on_ack(ack), .i_err_clr(clr),
    .o_clk_en(o_clk_en), .o_iso(o_iso), .o_ret(o_ret), .o_rstn(o_rstn),
    .o_pwr_on_req(o_pwr_on_req), .o_sleep_ack(o_sleep_ack), .o_busy(o_busy),
    .o_err(o_err), .o_state(o_state)
  );

  assign outs = {o_clk_en, o_iso, o_ret, o_rstn, o_pwr_on_req, o_sleep_ack, o_busy};

  always #5 clk = ~clk;

  typedef struct {
    logic       sleep;
    logic       pg;
    logic       ret;
    logic [3:0] off_dly;
    logic [3:0] on_dly;
    logic       ack;
    logic       clr;
    logic [3:0] es;
    logic [6:0] eo;
    logic       ee;
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge clk);
    #1;
    if (o_ret) ret_seen = 1'b1;
  endtask

  task automatic check(input string name, input logic [3:0] es,
                       input logic [6:0] eo, input logic ee);
    checks++;
    if (o_state !== es || outs !== eo || o_err !== ee) begin
      errors++;
      $display("FAIL %s: got state=%0d outs=%b err=%b, expected state=%0d outs=%b err=%b",
               name, o_state, outs, o_err, es, eo, ee);
    end
  endtask

  task automatic wait_state(input string name, input logic [3:0] target, input int budget);
    int n = 0;
    while (o_state !== target && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (o_state !== target) begin
      errors++;
      $display("FAIL %s: got state=%0d after %0d cycles, expected state=%0d", name, o_state, n, target);
    end
  endtask

  initial begin
    // sleep pg ret offd ond ack clr | state outs err
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd1,  7'b0001101, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd6,  7'b0001110, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd6,  7'b0001110, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0,  7'b1001100, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0,  7'b1001100, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 4'd1,  7'b0001101, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd2,  7'b0101101, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd4,  7'b0100101, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 4'd5,  7'b0100001, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 4'd5,  7'b0100001, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 4'd6,  7'b0100010, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 4'd6,  7'b0100010, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 4'd7,  7'b0100101, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd8,  7'b0101101, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd10, 7'b0001101, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0,  7'b1001100, 1'b0};

    step();
    step();
    check("reset_hold", 4'd0, RST_OUTS, 1'b0);
    rst = 1'b0;
    step();
    check("reset_release", 4'd0, RST_OUTS, 1'b0);

    // Clock-gate-only with zero delay, then a short full gate with latched modes.
    for (int i = 0; i < 16; i++) begin
      sleep = tbl[i].sleep; pg = tbl[i].pg; ret_en = tbl[i].ret;
      off_dly = tbl[i].off_dly; on_dly = tbl[i].on_dly;
      ack = tbl[i].ack; clr = tbl[i].clr;
      step();
      check($sformatf("vec%0d", i), tbl[i].es, tbl[i].eo, tbl[i].ee);
    end

    // Full power-gate off with retention, off_dly=3.
    sleep = 1'b1; pg = 1'b1; ret_en = 1'b1; off_dly = 4'd3; ack = 1'b1;
    step();
    check("pg_off_clk_T", 4'd1, 7'b0001101, 1'b0);
    step(); step();
    check("pg_off_clk_T2", 4'd1, 7'b0001101, 1'b0);
    step();
    check("pg_off_iso_T3", 4'd2, 7'b0101101, 1'b0);
    repeat (3) step();
    check("pg_off_ret_T6", 4'd3, 7'b0111101, 1'b0);
    repeat (3) step();
    check("pg_off_rst_T9", 4'd4, 7'b0110101, 1'b0);
    repeat (3) step();
    check("pg_off_wait_T12", 4'd5, 7'b0110001, 1'b0);
    ack = 1'b0;
    step();
    check("pg_off_done", 4'd6, 7'b0110010, 1'b0);

    // Power-gate on, on_dly=2, ack delayed 5 cycles.
    sleep = 1'b0; on_dly = 4'd2;
    step();
    check("pg_on_wait", 4'd7, 7'b0110101, 1'b0);
    repeat (5) step();
    check("pg_on_wait5", 4'd7, 7'b0110101, 1'b0);
    ack = 1'b1;
    step();
    check("pg_on_rst", 4'd8, 7'b0111101, 1'b0);
    step(); step();
    check("pg_on_ret", 4'd9, 7'b0101101, 1'b0);
    step(); step();
    check("pg_on_iso", 4'd10, 7'b0001101, 1'b0);
    step(); step();
    check("pg_on_done", 4'd0, RST_OUTS, 1'b0);

    // Retention skip with acknowledge timeout.
    ret_seen = 1'b0;
    sleep = 1'b1; pg = 1'b1; ret_en = 1'b0; off_dly = 4'd1;
    repeat (4) step();
    ack = 1'b0;
    step();
    check("noret_off", 4'd6, 7'b0100010, 1'b0);
    sleep = 1'b0; on_dly = 4'd1;
    step();
    for (int i = 1; i <= 70; i++) begin
      clr = (i == 64) ? 1'b1 : 1'b0;
      step();
      if (i == 63) check("to_before", 4'd7, 7'b0100101, 1'b0);
      if (i == 64) check("to_set_wins", 4'd7, 7'b0100101, 1'b1);
    end
    clr = 1'b0;
    check("to_still_wait", 4'd7, 7'b0100101, 1'b1);
    ack = 1'b1;
    step();
    check("to_ack_rst", 4'd8, 7'b0101101, 1'b1);
    step();
    check("noret_on_iso", 4'd10, 7'b0001101, 1'b1);
    step();
    check("noret_on_done", 4'd0, RST_OUTS, 1'b1);
    checks++;
    if (ret_seen !== 1'b0) begin
      errors++;
      $display("FAIL ret_never: got ret_seen=%b, expected 0", ret_seen);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("err_clr", 4'd0, RST_OUTS, 1'b0);

    // Request pulse: off sequence still runs to OFF, then wakes.
    sleep = 1'b1; pg = 1'b1; ret_en = 1'b1; off_dly = 4'd2; on_dly = 4'd2; ack = 1'b1;
    step(); step();
    sleep = 1'b0;
    step();
    check("rev_iso", 4'd2, 7'b0101101, 1'b0);
    step(); step();
    check("rev_ret", 4'd3, 7'b0111101, 1'b0);
    repeat (4) step();
    check("rev_wait_off", 4'd5, 7'b0110001, 1'b0);
    ack = 1'b0;
    step();
    check("rev_off", 4'd6, 7'b0110010, 1'b0);
    step();
    check("rev_wait_on", 4'd7, 7'b0110101, 1'b0);
    ack = 1'b1;
    wait_state("rev_back_on", 4'd0, 20);
    check("rev_on", 4'd0, RST_OUTS, 1'b0);

    // Reset asserted in OFF_RET.
    sleep = 1'b1;
    step();
    repeat (4) step();
    check("mid_off_ret", 4'd3, 7'b0111101, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst", 4'd0, RST_OUTS, 1'b0);
    step();
    check("rst_held", 4'd0, RST_OUTS, 1'b0);
    sleep = 1'b0;
    rst = 1'b0;
    step(); step();
    check("post_rst_on", 4'd0, RST_OUTS, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pd_pwr_sequencer.md
PD_PWR_SEQUENCER -- requirements
Module: pd_pwr_sequencer

Interface
REQ-001 The block SHALL have parameters (name, default, meaning):
  DLY_W, 4, width of the per-step delay inputs.
  TO_CYC, 64, power-switch acknowledge timeout in cycles; TO_CYC >= 1.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  i_aon_clk  in  1  always-on clock; one clock domain only.
  i_soc_pwr_on_rst  in  1  reset, asynchronous, active-high.
  i_sleep_req  in  1  level request: 1 = power domain down, 0 = power domain up.
  i_pg_en  in  1  1 = full power-gate sequence, 0 = clock-gate-only sequence.
  i_ret_en  in  1  1 = include retention step.
  i_pwr_off_dly  in  DLY_W  dwell cycles per power-off step.
  i_pwr_on_dly  in  DLY_W  dwell cycles per power-on step.
  i_pwr_on_ack  in  1  power-switch acknowledge (1 = domain powered).
  i_err_clr  in  1  clears o_err.
  o_clk_en, o_iso, o_ret, o_rstn, o_pwr_on_req  out  1 each  domain controls.
  o_sleep_ack  out  1  domain is in the OFF state.
  o_busy  out  1  a sequence is in progress.
  o_err  out  1  sticky acknowledge-timeout flag.
  o_state  out  4  current FSM state encoding.

Function
REQ-003 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-004 The FSM SHALL use these states and encodings: ON=0, OFF_CLK=1, OFF_ISO=2, OFF_RET=3, OFF_RST=4, WAIT_OFF=5, OFF=6, WAIT_ON=7, ON_RST=8, ON_RET=9, ON_ISO=10. o_state SHALL equal the current encoding.
REQ-005 Each control output change SHALL occur on the same edge as the state transition that enters the named step state.
REQ-006 Dwell in OFF_* and ON_* step states SHALL be max(D,1) cycles, where D is the latched delay for that sequence; a delay of 0 SHALL be treated as 1.
REQ-007 i_pg_en, i_ret_en and the relevant delay input SHALL be latched on the edge that leaves ON or OFF, and SHALL be held for the whole sequence.
REQ-008 From ON with i_sleep_req=1, the block SHALL set o_clk_en=0 and enter OFF_CLK.
REQ-009 At the end of the OFF_CLK dwell with pg=0, the block SHALL enter OFF; with pg=1 it SHALL set o_iso=1 and enter OFF_ISO.
REQ-010 At the end of the OFF_ISO dwell, the block SHALL set o_ret=1 and enter OFF_RET if ret=1; otherwise it SHALL set o_rstn=0 and enter OFF_RST.
REQ-011 At the end of the OFF_RET dwell, the block SHALL set o_rstn=0 and enter OFF_RST.
REQ-012 At the end of the OFF_RST dwell, the block SHALL set o_pwr_on_req=0 and enter WAIT_OFF.
REQ-013 In WAIT_OFF, i_pwr_on_ack=0 SHALL move the FSM to OFF.
REQ-014 From OFF with i_sleep_req=0 and pg=0, the block SHALL set o_clk_en=1 and enter ON in one cycle.
REQ-015 From OFF with i_sleep_req=0 and pg=1, the block SHALL set o_pwr_on_req=1 and enter WAIT_ON.
REQ-016 In WAIT_ON, i_pwr_on_ack=1 SHALL set o_rstn=1 and enter ON_RST.
REQ-017 At the end of the ON_RST dwell, the block SHALL set o_ret=0 and enter ON_RET if ret=1; otherwise it SHALL set o_iso=0 and enter ON_ISO.
REQ-018 At the end of the ON_RET dwell, the block SHALL set o_iso=0 and enter ON_ISO.
REQ-019 At the end of the ON_ISO dwell, the block SHALL set o_clk_en=1 and enter ON.
REQ-020 A sequence SHALL never abort. A change of i_sleep_req mid-sequence SHALL be acted on only after ON or OFF is reached, with at least one cycle spent in that state.
REQ-021 o_sleep_ack SHALL be 1 exactly while the state is OFF.
REQ-022 o_busy SHALL be 1 exactly while the state is neither ON nor OFF.
REQ-023 The timeout counter SHALL clear on entry to WAIT_ON or WAIT_OFF and SHALL increment each cycle while waiting, saturating at TO_CYC; its width SHALL be $clog2(TO_CYC+1).
REQ-024 o_err SHALL set on the cycle the counter reaches TO_CYC. The FSM SHALL keep waiting for the acknowledge and SHALL NOT force any output.
REQ-025 o_err SHALL clear on i_err_clr=1. If set and clear occur in the same cycle, set SHALL win.
REQ-026 Delay counters SHALL count down from the latched value; no counter SHALL wrap.

Reset
REQ-027 While i_soc_pwr_on_rst=1, the block SHALL asynchronously force: state=ON, o_clk_en=1, o_iso=0, o_ret=0, o_rstn=1, o_pwr_on_req=1, o_sleep_ack=0, o_busy=0, o_err=0, and all counters and latched modes =0.
REQ-028 Reset asserted mid-sequence SHALL immediately return the block to the REQ-027 values; after release, the FSM SHALL begin from ON with no residual sequence.

Verification
REQ-029 Full power-gate off: pg=1, ret=1, off_dly=3, sleep_req rise -> clk_en=0 at T, iso=1 at T+3, ret=1 at T+6, rstn=0 at T+9, pwr_on_req=0 at T+12; ack drop -> OFF, sleep_ack=1.
REQ-030 Power-gate on: from REQ-029 OFF, on_dly=2, sleep_req=0, ack after 5 cycles -> rstn=1, then ret=0 +2, iso=0 +4, clk_en=1 +6; state ON, busy=0.
REQ-031 Clock-gate only with zero delay: pg=0, off_dly=0 -> clk_en=0 then OFF 1 cycle later; iso, ret, rstn, pwr_on_req unchanged; wake -> clk_en=1 in 1 cycle.
REQ-032 Retention skip with timeout: pg=1, ret=0, TO_CYC=64, ack withheld 70 cycles in WAIT_ON -> err=1 at cycle 64, o_ret never 1; ack=1 -> sequence completes; err_clr -> err=0.
REQ-033 Request reversal plus reset mid-sequence: sleep_req pulses 1 for 2 cycles -> full off sequence completes to OFF, then on sequence begins; reset asserted in OFF_RET -> all outputs at REQ-027 values the same cycle.
